// File: rtl/tile_pixel_renderer_pkg.sv
// Shared encodings and default geometry for the tile pixel renderer.
// Holds the tile-type and direction enums, the fixed colours and the default maze and tile sizes.
package tile_pixel_renderer_pkg;

  localparam int unsigned DEF_TILE_SIZE = 16;
  localparam int unsigned DEF_MAP_W     = 28;
  localparam int unsigned DEF_MAP_H     = 31;

  typedef enum logic [1:0] {
    TILE_EMPTY   = 2'd0,
    TILE_WALL    = 2'd1,
    TILE_DOT     = 2'd2,
    TILE_BIG_DOT = 2'd3
  } tile_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  localparam logic [11:0] RGB_BG     = 12'h000;
  localparam logic [11:0] RGB_WALL   = 12'h00F;
  localparam logic [11:0] RGB_DOT    = 12'hFDB;
  localparam logic [11:0] RGB_PLAYER = 12'hFF0;

endpackage

// File: rtl/tile_pixel_renderer_if.sv
// Pixel stream into the renderer and the RGB stream out of it.
// master drives coordinates and sinks colours; slave is the renderer side.
interface tile_pixel_renderer_if;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [11:0] rgb_out;
  logic        rgb_valid;

  modport master (
    output pix_valid, pix_x, pix_y,
    input  rgb_out, rgb_valid
  );

  modport slave (
    input  pix_valid, pix_x, pix_y,
    output rgb_out, rgb_valid
  );
endinterface

// File: rtl/tile_pixel_renderer_sprite_hit.sv
// Combinational sprite bounds test and sprite-relative pixel offset.
// The right and bottom edges are computed at 11 bits so sprites near 1023 cannot wrap around.
module tile_pixel_renderer_sprite_hit
  import tile_pixel_renderer_pkg::*;
#(
  parameter int unsigned TILE_SIZE = DEF_TILE_SIZE
) (
  input  logic [9:0]                   pix_x,
  input  logic [9:0]                   pix_y,
  input  logic [9:0]                   sx,
  input  logic [9:0]                   sy,
  output logic                         hit,
  output logic [$clog2(TILE_SIZE)-1:0] off_x,
  output logic [$clog2(TILE_SIZE)-1:0] off_y
);
  localparam int unsigned OFFW = $clog2(TILE_SIZE);

  logic [10:0] x_end;
  logic [10:0] y_end;

  assign x_end = {1'b0, sx} + 11'(TILE_SIZE);
  assign y_end = {1'b0, sy} + 11'(TILE_SIZE);

  assign hit = (pix_x >= sx) && ({1'b0, pix_x} < x_end) &&
               (pix_y >= sy) && ({1'b0, pix_y} < y_end);

  assign off_x = OFFW'(pix_x - sx);
  assign off_y = OFFW'(pix_y - sy);
endmodule

// File: rtl/tile_pixel_renderer.sv
// Three-stage per-pixel compositor: map lookup and sprite hit test, mask fetch, priority colour select.
// Build option PLAYER_MIRROR_EN flips the player sprite horizontally while it faces left.
module tile_pixel_renderer
  import tile_pixel_renderer_pkg::*;
#(
  parameter int unsigned TILE_SIZE   = DEF_TILE_SIZE,
  parameter int unsigned MAP_W       = DEF_MAP_W,
  parameter int unsigned MAP_H       = DEF_MAP_H,
  parameter int unsigned ANIM_PERIOD = 8,
  parameter logic [11:0] GHOST_RGB   = 12'hF00
) (
  input  logic                           clk,
  input  logic                           rst,
  tile_pixel_renderer_if.slave           pix,
  input  logic                           frame_start,
  output logic [9:0]                     map_addr,
  input  logic [1:0]                     map_data,
  input  logic [9:0]                     player_x,
  input  logic [9:0]                     player_y,
  input  logic [1:0]                     player_dir,
  input  logic [9:0]                     ghost_x,
  input  logic [9:0]                     ghost_y,
  input  logic [TILE_SIZE*TILE_SIZE-1:0] player_mask_f1,
  input  logic [TILE_SIZE*TILE_SIZE-1:0] player_mask_f2,
  input  logic [TILE_SIZE*TILE_SIZE-1:0] ghost_mask_f1,
  input  logic [TILE_SIZE*TILE_SIZE-1:0] ghost_mask_f2,
  input  logic [TILE_SIZE*TILE_SIZE-1:0] dot_mask,
  input  logic [TILE_SIZE*TILE_SIZE-1:0] big_dot_mask,
  output logic                           anim_sel
);
  localparam int unsigned OFFW = $clog2(TILE_SIZE);
  localparam int unsigned IDXW = $clog2(TILE_SIZE * TILE_SIZE);
  localparam int unsigned CNTW = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;

  logic [9:0]      sh_px, sh_py, sh_gx, sh_gy;
  dir_t            sh_dir;
  logic [CNTW-1:0] frame_cnt;

  logic [9:0]      tile_x, tile_y;
  logic            p_hit, g_hit;
  logic [OFFW-1:0] p_offx, p_offy, g_offx, g_offy, p_col;

  logic            s1_valid, s1_in_map, s1_anim, s1_p_hit, s1_g_hit;
  logic [OFFW-1:0] s1_row, s1_col, s1_p_row, s1_p_col, s1_g_row, s1_g_col;

  tile_t           s1_tile;
  logic [IDXW-1:0] tile_idx, p_idx, g_idx;
  logic [TILE_SIZE*TILE_SIZE-1:0] p_mask, g_mask;

  logic            s2_valid, s2_p, s2_g, s2_dot;
  tile_t           s2_tile;
  logic [11:0]     color;

  // Shadow positions and animation state change only on frame_start, so a
  // pixel presented in the same cycle still sees the previous frame's values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_px     <= '0;
      sh_py     <= '0;
      sh_gx     <= '0;
      sh_gy     <= '0;
      sh_dir    <= DIR_UP;
      frame_cnt <= '0;
      anim_sel  <= 1'b0;
    end else if (frame_start) begin
      sh_px  <= player_x;
      sh_py  <= player_y;
      sh_gx  <= ghost_x;
      sh_gy  <= ghost_y;
      sh_dir <= dir_t'(player_dir);
      if (frame_cnt == CNTW'(ANIM_PERIOD - 1)) begin
        frame_cnt <= '0;
        anim_sel  <= ~anim_sel;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign tile_x = 10'(pix.pix_x / TILE_SIZE);
  assign tile_y = 10'(pix.pix_y / TILE_SIZE);

  tile_pixel_renderer_sprite_hit #(.TILE_SIZE(TILE_SIZE)) u_player_hit (
    .pix_x (pix.pix_x),
    .pix_y (pix.pix_y),
    .sx    (sh_px),
    .sy    (sh_py),
    .hit   (p_hit),
    .off_x (p_offx),
    .off_y (p_offy)
  );

  tile_pixel_renderer_sprite_hit #(.TILE_SIZE(TILE_SIZE)) u_ghost_hit (
    .pix_x (pix.pix_x),
    .pix_y (pix.pix_y),
    .sx    (sh_gx),
    .sy    (sh_gy),
    .hit   (g_hit),
    .off_x (g_offx),
    .off_y (g_offy)
  );

`ifdef PLAYER_MIRROR_EN
  always_comb begin
    p_col = p_offx;
    if (sh_dir == DIR_LEFT) p_col = OFFW'(TILE_SIZE - 1) - p_offx;
  end
`else
  logic unused_dir;
  assign unused_dir = ^sh_dir;
  assign p_col      = p_offx;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      map_addr  <= '0;
      s1_in_map <= 1'b0;
      s1_anim   <= 1'b0;
      s1_row    <= '0;
      s1_col    <= '0;
      s1_p_hit  <= 1'b0;
      s1_p_row  <= '0;
      s1_p_col  <= '0;
      s1_g_hit  <= 1'b0;
      s1_g_row  <= '0;
      s1_g_col  <= '0;
    end else begin
      s1_valid <= pix.pix_valid;
      if (pix.pix_valid) begin
        map_addr  <= 10'(32'(tile_y) * MAP_W + 32'(tile_x));
        s1_in_map <= (32'(tile_x) < MAP_W) && (32'(tile_y) < MAP_H);
        s1_anim   <= anim_sel;
        s1_row    <= OFFW'(pix.pix_y % TILE_SIZE);
        s1_col    <= OFFW'(pix.pix_x % TILE_SIZE);
        s1_p_hit  <= p_hit;
        s1_p_row  <= p_offy;
        s1_p_col  <= p_col;
        s1_g_hit  <= g_hit;
        s1_g_row  <= g_offy;
        s1_g_col  <= g_offx;
      end
    end
  end

  assign s1_tile  = s1_in_map ? tile_t'(map_data) : TILE_EMPTY;
  assign tile_idx = IDXW'(s1_row) * IDXW'(TILE_SIZE) + IDXW'(s1_col);
  assign p_idx    = IDXW'(s1_p_row) * IDXW'(TILE_SIZE) + IDXW'(s1_p_col);
  assign g_idx    = IDXW'(s1_g_row) * IDXW'(TILE_SIZE) + IDXW'(s1_g_col);
  assign p_mask   = s1_anim ? player_mask_f2 : player_mask_f1;
  assign g_mask   = s1_anim ? ghost_mask_f2  : ghost_mask_f1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_tile  <= TILE_EMPTY;
      s2_p     <= 1'b0;
      s2_g     <= 1'b0;
      s2_dot   <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_tile <= s1_tile;
        s2_p    <= s1_p_hit && p_mask[p_idx];
        s2_g    <= s1_g_hit && g_mask[g_idx];
        s2_dot  <= ((s1_tile == TILE_DOT)     && dot_mask[tile_idx]) ||
                   ((s1_tile == TILE_BIG_DOT) && big_dot_mask[tile_idx]);
      end
    end
  end

  always_comb begin
    color = RGB_BG;
    if (s2_p)                        color = RGB_PLAYER;
    else if (s2_g)                   color = GHOST_RGB;
    else if (s2_dot)                 color = RGB_DOT;
    else if (s2_tile == TILE_WALL)   color = RGB_WALL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix.rgb_valid <= 1'b0;
      pix.rgb_out   <= '0;
    end else begin
      pix.rgb_valid <= s2_valid;
      if (s2_valid) pix.rgb_out <= color;
    end
  end
endmodule

// File: tb/tb_tile_pixel_renderer.sv
// Scoreboard bench for tile_pixel_renderer: directed cases from the test plan plus randomized pixels.
// Expected colours come from a direct per-pixel reference model of the compositing rules.
module tb_tile_pixel_renderer;
  localparam int TS = 16;
  localparam int MW = 28;
  localparam int MH = 31;
  localparam int AP = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tile_pixel_renderer_if pif();
  logic             frame_start;
  logic [9:0]       map_addr;
  logic [1:0]       map_data;
  logic [9:0]       player_x, player_y, ghost_x, ghost_y;
  logic [1:0]       player_dir;
  logic [TS*TS-1:0] pf1, pf2, gf1, gf2, dotm, bigm;
  logic             anim_sel;
  logic [1:0]       map_mem [0:1023];

  assign map_data = map_mem[map_addr];

  tile_pixel_renderer #(
    .TILE_SIZE   (TS),
    .MAP_W       (MW),
    .MAP_H       (MH),
    .ANIM_PERIOD (AP),
    .GHOST_RGB   (12'hF00)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pix            (pif.slave),
    .frame_start    (frame_start),
    .map_addr       (map_addr),
    .map_data       (map_data),
    .player_x       (player_x),
    .player_y       (player_y),
    .player_dir     (player_dir),
    .ghost_x        (ghost_x),
    .ghost_y        (ghost_y),
    .player_mask_f1 (pf1),
    .player_mask_f2 (pf2),
    .ghost_mask_f1  (gf1),
    .ghost_mask_f2  (gf2),
    .dot_mask       (dotm),
    .big_dot_mask   (bigm),
    .anim_sel       (anim_sel)
  );

  typedef struct {
    int unsigned due;
    logic [11:0] val;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        addr_q[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  logic [11:0] last_rgb = 12'h000;

  int m_px, m_py, m_gx, m_gy, m_dir, m_frames;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int m_anim();
    return (m_frames / AP) % 2;
  endfunction

  function automatic logic [11:0] model_pix(input int x, input int y);
    int tx, ty, tile, r, c, pc;
    logic [TS*TS-1:0] pm, gm;
    tx = x / TS;
    ty = y / TS;
    r  = y % TS;
    c  = x % TS;
    tile = 0;
    if (tx < MW && ty < MH) tile = int'(map_mem[ty * MW + tx]);
    pm = (m_anim() == 1) ? pf2 : pf1;
    gm = (m_anim() == 1) ? gf2 : gf1;
    if (x >= m_px && x < m_px + TS && y >= m_py && y < m_py + TS) begin
      pc = x - m_px;
`ifdef PLAYER_MIRROR_EN
      if (m_dir == 2) pc = TS - 1 - pc;
`endif
      if (pm[8'((y - m_py) * TS + pc)]) return 12'hFF0;
    end
    if (x >= m_gx && x < m_gx + TS && y >= m_gy && y < m_gy + TS)
      if (gm[8'((y - m_gy) * TS + (x - m_gx))]) return 12'hF00;
    if ((tile == 2 && dotm[8'(r * TS + c)]) || (tile == 3 && bigm[8'(r * TS + c)]))
      return 12'hFDB;
    if (tile == 1) return 12'h00F;
    return 12'h000;
  endfunction

  function automatic logic [TS*TS-1:0] rand_vec();
    logic [TS*TS-1:0] v;
    for (int unsigned k = 0; k < TS * TS / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic drive(input bit v, input int x, input int y, input bit fs);
    pif.pix_valid = v;
    pif.pix_x     = 10'(x);
    pif.pix_y     = 10'(y);
    frame_start   = fs;
    if (v && !rst) begin
      exp_q.push_back('{cyc + 3, model_pix(x, y)});
      addr_q.push_back('{cyc + 1, 12'((y / TS) * MW + x / TS)});
    end
    if (fs && !rst) begin
      m_px = int'(player_x);
      m_py = int'(player_y);
      m_gx = int'(ghost_x);
      m_gy = int'(ghost_y);
      m_dir = int'(player_dir);
      m_frames++;
    end
    @(posedge clk);
    #1;
    if (fs && !rst) chk("anim_sel", 32'(anim_sel), 32'(m_anim()));
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    exp_q.delete();
    addr_q.delete();
    m_px = 0; m_py = 0; m_gx = 0; m_gy = 0; m_dir = 0; m_frames = 0;
    repeat (n) drive(1'b1, int'($urandom_range(0, 500)), int'($urandom_range(0, 500)), 1'b1);
    rst = 1'b0;
  endtask

  task automatic randomize_content();
    pf1 = rand_vec(); pf2 = rand_vec(); gf1 = rand_vec(); gf2 = rand_vec();
    dotm = rand_vec(); bigm = rand_vec();
    for (int a = 0; a < 1024; a++) map_mem[a] = 2'($urandom_range(0, 3));
  endtask

  // Monitor: each cycle either the oldest expected pixel is due, or the output must be idle and holding.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_rgb_valid", 32'(pif.rgb_valid), 32'd0);
      chk("rst_rgb_out", 32'(pif.rgb_out), 32'd0);
      chk("rst_anim_sel", 32'(anim_sel), 32'd0);
      chk("rst_map_addr", 32'(map_addr), 32'd0);
      last_rgb = 12'h000;
    end else begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rgb_valid", 32'(pif.rgb_valid), 32'd1);
        chk("rgb_out", 32'(pif.rgb_out), 32'(e.val));
        last_rgb = e.val;
      end else begin
        chk("gap_rgb_valid", 32'(pif.rgb_valid), 32'd0);
        chk("hold_rgb_out", 32'(pif.rgb_out), 32'(last_rgb));
      end
      if (addr_q.size() > 0 && addr_q[0].due == cyc) begin
        exp_t a;
        a = addr_q.pop_front();
        chk("map_addr", 32'(map_addr), 32'(a.val));
      end
    end
  end

  initial begin
    int x, y;
    bit fs;
    rst = 1'b1;
    pif.pix_valid = 1'b0; pif.pix_x = '0; pif.pix_y = '0;
    frame_start = 1'b0;
    player_x = '0; player_y = '0; ghost_x = '0; ghost_y = '0; player_dir = '0;
    randomize_content();
    do_reset(5);
    drive(1'b1, 40, 40, 1'b0);
    idle(4);

    // Directed scene: tile 0 is a dot, tile 1 a wall, bit 5*16+3 is the probe pixel.
    for (int a = 0; a < 1024; a++) map_mem[a] = 2'd0;
    map_mem[0] = 2'd2;
    map_mem[1] = 2'd1;
    pf1 = '0; pf2 = '0; gf1 = '0; gf2 = '0; dotm = '0; bigm = '0;
    dotm[83] = 1'b1; pf1[83] = 1'b1; gf1[83] = 1'b1;
    drive(1'b0, 0, 0, 1'b1);
    drive(1'b1, 20, 5, 1'b0);
    drive(1'b1, 3, 5, 1'b0);
    idle(4);
    pf1[83] = 1'b0;
    drive(1'b1, 3, 5, 1'b0);
    idle(4);
    gf1[83] = 1'b0; pf2[83] = 1'b1;
    drive(1'b1, 3, 5, 1'b1);
    drive(1'b1, 3, 5, 1'b0);
    idle(4);
    map_mem[731] = 2'd1;
    drive(1'b1, 500, 400, 1'b0);
    idle(4);

    // Back-to-back stream over alternating wall/empty tiles with sprites parked off-map.
    for (int k = 0; k < 8; k++) map_mem[k] = (k % 2 == 0) ? 2'd1 : 2'd0;
    player_x = 10'd600; player_y = 10'd500; ghost_x = 10'd600; ghost_y = 10'd500;
    drive(1'b0, 0, 0, 1'b1);
    for (int k = 0; k < 8; k++) drive(1'b1, k * TS + 4, 4, 1'b0);
    idle(2);
    for (int k = 0; k < 3; k++) drive(1'b1, k * TS, 0, 1'b0);
    do_reset(3);
    idle(4);

    randomize_content();
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        idle(4);
        randomize_content();
      end
      player_x = 10'($urandom_range(0, 480)); player_y = 10'($urandom_range(0, 480));
      ghost_x  = 10'($urandom_range(0, 480)); ghost_y  = 10'($urandom_range(0, 480));
      player_dir = 2'($urandom_range(0, 3));
      fs = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 2))
        0: begin x = m_px + int'($urandom_range(0, 17)) - 1; y = m_py + int'($urandom_range(0, 17)) - 1; end
        1: begin x = m_gx + int'($urandom_range(0, 17)) - 1; y = m_gy + int'($urandom_range(0, 17)) - 1; end
        default: begin x = int'($urandom_range(0, 520)); y = int'($urandom_range(0, 520)); end
      endcase
      if (x < 0) x = 0;
      if (y < 0) y = 0;
      drive($urandom_range(0, 3) != 0, x, y, fs);
    end

    idle(6);
    chk("drain_rgb_queue", 32'(exp_q.size()), 32'd0);
    chk("drain_addr_queue", 32'(addr_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
